// File: rtl/calc_req_dispatcher.sv
// Valid/ready command intake buffered per port, driving each port's two-cycle request protocol with tag tracking.
// Define CALC_DISP_TIMEOUT_EN to build per-tag watchdogs that retire requests that never see a response.
module calc_req_dispatcher #(
  parameter int NUM_PORTS      = 4,
  parameter int CMD_WIDTH      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            PClk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PW-1:0]                   in_port,
  input  logic [CMD_WIDTH-1:0]            in_cmd,
  input  logic [DATA_WIDTH-1:0]           in_op1,
  input  logic [DATA_WIDTH-1:0]           in_op2,
  output logic [NUM_PORTS*CMD_WIDTH-1:0]  req_cmd,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_PORTS*TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_PORTS*2-1:0]          out_resp,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0]  out_tag,
  output logic [NUM_PORTS-1:0]            iss_valid,
  output logic [NUM_PORTS*TAG_WIDTH-1:0]  iss_tag,
  output logic [NUM_PORTS-1:0]            cpl_valid,
  output logic [NUM_PORTS*2-1:0]          cpl_resp,
  output logic [NUM_PORTS*TAG_WIDTH-1:0]  cpl_tag,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] cpl_data,
  output logic [NUM_PORTS-1:0]            cpl_spurious,
  output logic [NUM_PORTS-1:0]            cpl_timeout
);
  localparam int NT = 1 << TAG_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA2} state_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("calc_req_dispatcher: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
  end

  // Padded so that an in_port value beyond NUM_PORTS reads as not-full.
  logic [(1<<PW)-1:0] w_full;
  assign in_ready = ~w_full[in_port];
  for (genvar q = NUM_PORTS; q < (1 << PW); q++) begin : g_pad
    assign w_full[q] = 1'b0;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_t                r_state, w_state_nxt;
    logic [CMD_WIDTH-1:0]  r_f_cmd [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_f_op1 [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_f_op2 [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr, r_rd_ptr;
    logic [NT-1:0]         r_busy, w_alloc, w_clr;
    logic [DATA_WIDTH-1:0] r_op2, r_req_data, w_req_data_nxt, w_rsp_data, r_cpl_data;
    logic [CMD_WIDTH-1:0]  r_req_cmd, w_req_cmd_nxt;
    logic [TAG_WIDTH-1:0]  r_req_tag, w_req_tag_nxt, w_free_tag, w_rsp_tag, w_to_tag, r_cpl_tag;
    logic [1:0]            w_rsp, r_cpl_resp;
    logic                  r_iss, w_iss_nxt, w_empty, w_wr, w_has_free, w_issue;
    logic                  w_rsp_vld, w_rsp_busy, w_to_fire;
    logic                  r_cpl_valid, r_cpl_spur, r_cpl_to;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full[p]  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr       = in_valid && (in_port == PW'(p)) && !w_full[p] && (in_cmd != '0);
    assign w_rsp      = out_resp[p*2 +: 2];
    assign w_rsp_tag  = out_tag[p*TAG_WIDTH +: TAG_WIDTH];
    assign w_rsp_data = out_data[p*DATA_WIDTH +: DATA_WIDTH];
    assign w_rsp_vld  = |w_rsp;
    assign w_rsp_busy = r_busy[w_rsp_tag];

    always_comb begin
      w_has_free = 1'b0;
      w_free_tag = '0;
      for (int t = NT - 1; t >= 0; t--) begin
        if (!r_busy[t]) begin
          w_has_free = 1'b1;
          w_free_tag = TAG_WIDTH'(t);
        end
      end
    end

    // Allocation looks at the pre-retire mask, so a tag freed this cycle is only reusable next cycle.
    assign w_issue = !w_empty && w_has_free && (r_state != S_CMD);
    assign w_alloc = w_issue ? (NT'(1) << w_free_tag) : '0;
    assign w_clr   = ((w_rsp_vld && w_rsp_busy) ? (NT'(1) << w_rsp_tag) : '0) |
                     (w_to_fire ? (NT'(1) << w_to_tag) : '0);

    always_ff @(posedge PClk) begin
      if (w_wr) begin
        r_f_cmd[r_wr_ptr[AW-1:0]] <= in_cmd;
        r_f_op1[r_wr_ptr[AW-1:0]] <= in_op1;
        r_f_op2[r_wr_ptr[AW-1:0]] <= in_op2;
      end
      if (w_issue) r_op2 <= r_f_op2[r_rd_ptr[AW-1:0]];
    end

    always_ff @(posedge PClk) begin
      if (reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_busy   <= '0;
        r_state  <= S_IDLE;
      end else begin
        if (w_wr)    r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_issue) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_busy  <= (r_busy | w_alloc) & ~w_clr;
        r_state <= w_state_nxt;
      end
    end

    always_comb begin
      w_state_nxt    = r_state;
      w_req_cmd_nxt  = '0;
      w_req_data_nxt = '0;
      w_req_tag_nxt  = '0;
      w_iss_nxt      = 1'b0;
      case (r_state)
        S_CMD: begin
          w_state_nxt    = S_DATA2;
          w_req_data_nxt = r_op2;
          w_req_tag_nxt  = r_req_tag;
        end
        default: begin
          if (w_issue) begin
            w_state_nxt    = S_CMD;
            w_req_cmd_nxt  = r_f_cmd[r_rd_ptr[AW-1:0]];
            w_req_data_nxt = r_f_op1[r_rd_ptr[AW-1:0]];
            w_req_tag_nxt  = w_free_tag;
            w_iss_nxt      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      endcase
    end

    always_ff @(posedge PClk) begin
      if (reset) begin
        r_req_cmd   <= '0;
        r_req_data  <= '0;
        r_req_tag   <= '0;
        r_iss       <= 1'b0;
        r_cpl_valid <= 1'b0;
        r_cpl_spur  <= 1'b0;
        r_cpl_to    <= 1'b0;
        r_cpl_resp  <= '0;
        r_cpl_tag   <= '0;
        r_cpl_data  <= '0;
      end else begin
        r_req_cmd   <= w_req_cmd_nxt;
        r_req_data  <= w_req_data_nxt;
        r_req_tag   <= w_req_tag_nxt;
        r_iss       <= w_iss_nxt;
        r_cpl_valid <= w_rsp_vld || w_to_fire;
        r_cpl_spur  <= w_rsp_vld && !w_rsp_busy;
        r_cpl_to    <= w_to_fire;
        r_cpl_resp  <= w_rsp;
        r_cpl_tag   <= w_rsp_vld ? w_rsp_tag : (w_to_fire ? w_to_tag : '0);
        r_cpl_data  <= w_rsp_vld ? w_rsp_data : '0;
      end
    end

`ifdef CALC_DISP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_wd [NT];
    logic          w_to_any;

    // Counters saturate at the limit so a timeout deferred by a real response still fires.
    always_ff @(posedge PClk) begin
      for (int t = 0; t < NT; t++) begin
        if (reset || w_alloc[t])
          r_wd[t] <= '0;
        else if (r_busy[t] && r_wd[t] != CW'(TIMEOUT_CYCLES - 1))
          r_wd[t] <= r_wd[t] + CW'(1);
      end
    end

    always_comb begin
      w_to_any = 1'b0;
      w_to_tag = '0;
      for (int t = NT - 1; t >= 0; t--) begin
        if (r_busy[t] && r_wd[t] == CW'(TIMEOUT_CYCLES - 1)) begin
          w_to_any = 1'b1;
          w_to_tag = TAG_WIDTH'(t);
        end
      end
    end
    assign w_to_fire = w_to_any && !w_rsp_vld;
`else
    assign w_to_fire = 1'b0;
    assign w_to_tag  = '0;
`endif

    assign req_cmd[p*CMD_WIDTH +: CMD_WIDTH]     = r_req_cmd;
    assign req_data[p*DATA_WIDTH +: DATA_WIDTH]  = r_req_data;
    assign req_tag[p*TAG_WIDTH +: TAG_WIDTH]     = r_req_tag;
    assign iss_valid[p]                          = r_iss;
    assign iss_tag[p*TAG_WIDTH +: TAG_WIDTH]     = r_req_tag;
    assign cpl_valid[p]                          = r_cpl_valid;
    assign cpl_resp[p*2 +: 2]                    = r_cpl_resp;
    assign cpl_tag[p*TAG_WIDTH +: TAG_WIDTH]     = r_cpl_tag;
    assign cpl_data[p*DATA_WIDTH +: DATA_WIDTH]  = r_cpl_data;
    assign cpl_spurious[p]                       = r_cpl_spur;
    assign cpl_timeout[p]                        = r_cpl_to;
  end
endmodule
